// File: rtl/dram_axi_rd_ctrl_pkg.sv
// dram_axi_rd_ctrl_pkg: MIG command codes, line geometry and FSM state shared by the DRAM AXI read and write paths
package dram_axi_rd_ctrl_pkg;
  localparam logic [2:0] MIG_CMD_READ = 3'b001;
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam int BEATS_PER_LINE = 4;
  localparam int LINE_W = 128;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] l, input logic [1:0] i);
    return l[32*i +: 32];
  endfunction
endpackage

// File: rtl/dram_sync_fifo.sv
// dram_sync_fifo: show-ahead synchronous FIFO, dout is the head entry whenever !empty
module dram_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = wr_q == rd_q;
    dout = mem[rd_q[AW-1:0]];
    wr_d = wr_q + PW'(push && !full);
    rd_d = rd_q + PW'(pop && !empty);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/dram_axi_rd_ctrl.sv
// dram_axi_rd_ctrl: AXI read slave issuing MIG read commands and replaying each 128-bit line as a 4-beat burst, critical word first
module dram_axi_rd_ctrl
  import dram_axi_rd_ctrl_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int OUTSTD = 4,
  parameter int APP_AW = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic              rlast,
  output logic [APP_AW-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  input  logic [LINE_W-1:0] app_rd_data,
  input  logic              app_rd_data_end,
  input  logic              app_rd_data_valid,
  output logic              busy
);
  localparam int OW = $clog2(OUTSTD) + 1;
  localparam int TW = ID_W + 2;
  logic [TW-1:0] tag_dout;
  logic [LINE_W-1:0] line_dout, line_q, line_d;
  logic tag_full, tag_empty, line_full, line_empty;
  logic ar_hs, r_hs, last_hs, load, unused;
  rd_state_e state_q, state_d;
  logic [1:0] beat_q, beat_d, w_q, w_d;
  logic [OW-1:0] outst_q, outst_d;
  logic app_en_q, app_en_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [APP_AW-1:0] app_addr_q, app_addr_d;
  logic [2:0] app_cmd_q;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  assign unused = &{1'b0, app_rd_data_end, tag_full, araddr[31:28], araddr[1:0]};
  dram_sync_fifo #(.W(TW), .DEPTH(OUTSTD)) u_tag_fifo (
    .clk, .rst, .push(ar_hs), .din({arid, araddr[3:2]}), .pop(load),
    .dout(tag_dout), .full(tag_full), .empty(tag_empty)
  );
  dram_sync_fifo #(.W(LINE_W), .DEPTH(OUTSTD)) u_line_fifo (
    .clk, .rst, .push(app_rd_data_valid), .din(app_rd_data), .pop(load),
    .dout(line_dout), .full(line_full), .empty(line_empty)
  );
  // The head line is moved into line_q when its burst starts, so the FIFO head is already the next line at rlast
  always_comb begin
    arready = !app_en_q && (outst_q < OW'(OUTSTD));
    ar_hs = arvalid && arready;
    r_hs = rvalid_q && rready;
    last_hs = r_hs && rlast_q;
    load = (state_q == RD_IDLE || last_hs) && !tag_empty && !line_empty;
    outst_d = outst_q + OW'(ar_hs) - OW'(last_hs);
    app_en_d = ar_hs || (app_en_q && !app_rdy);
    app_addr_d = ar_hs ? APP_AW'({1'b0, araddr[27:4], 3'b000}) : app_addr_q;
    state_d = load ? RD_BURST : last_hs ? RD_IDLE : state_q;
    beat_d = load ? 2'd0 : r_hs ? beat_q + 2'd1 : beat_q;
    w_d = load ? tag_dout[1:0] : w_q;
    line_d = load ? line_dout : line_q;
    rid_d = load ? tag_dout[TW-1:2] : rid_q;
    rvalid_d = load || (rvalid_q && !last_hs);
    rlast_d = load ? 1'b0 : r_hs ? beat_q == 2'(BEATS_PER_LINE - 2) : rlast_q;
    rdata_d = load ? line_word(line_dout, tag_dout[1:0]) : r_hs ? line_word(line_q, w_q + beat_q + 2'd1) : rdata_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RD_IDLE;
      beat_q <= '0;
      w_q <= '0;
      outst_q <= '0;
      app_en_q <= 1'b0;
      app_addr_q <= '0;
      app_cmd_q <= '0;
      line_q <= '0;
      rid_q <= '0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      w_q <= w_d;
      outst_q <= outst_d;
      app_en_q <= app_en_d;
      app_addr_q <= app_addr_d;
      app_cmd_q <= MIG_CMD_READ;
      line_q <= line_d;
      rid_q <= rid_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
    end
  assign app_en = app_en_q;
  assign app_addr = app_addr_q;
  assign app_cmd = app_cmd_q;
  assign rvalid = rvalid_q;
  assign rid = rid_q;
  assign rdata = rdata_q;
  assign rlast = rlast_q;
  assign busy = (outst_q != '0) || app_en_q;
  a_no_unsolicited: assert property (@(posedge clk) disable iff (rst)
    !(app_rd_data_valid && (line_full || tag_empty)));
endmodule

// File: tb/tb_dram_axi_rd_ctrl.sv
// tb_dram_axi_rd_ctrl: scoreboard bench with a 10-cycle-latency MIG model behind the read controller
module tb_dram_axi_rd_ctrl;
  logic clk = 0, rst = 1;
  logic arvalid = 0, arready, rvalid, rready = 1, rlast, app_en, app_rdy = 1;
  logic app_rd_data_end = 1, app_rd_data_valid = 0, busy;
  logic [3:0] arid = 0, rid;
  logic [31:0] araddr = 0, rdata;
  logic [27:0] app_addr;
  logic [2:0] app_cmd;
  logic [127:0] app_rd_data = 0;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {int due; logic [127:0] line;} mig_t;
  mig_t mq[$];
  logic [36:0] exp_q[$];
  logic [27:0] cmd_q[$];
  dram_axi_rd_ctrl #(.ID_W(4), .OUTSTD(4), .APP_AW(28)) dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask
  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'h11111111 * (k + 1) + {a - 28'h20, 4'h0};
    return l;
  endfunction
  function automatic logic [27:0] app_of(input logic [31:0] a);
    return {1'b0, a[27:4], 3'b000};
  endfunction
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr);
    logic [127:0] l;
    int n = 0;
    arvalid = 1; arid = id; araddr = addr;
    while (!arready && n < 200) begin @(posedge clk); #1; n++; end
    if (!arready) chk("ar_timeout", 0, 1);
    else begin
      l = line_of(app_of(addr));
      cmd_q.push_back(app_of(addr));
      for (int b = 0; b < 4; b++) exp_q.push_back({id, l[32*((addr[3:2] + b) % 4) +: 32], b == 3});
    end
    @(posedge clk); #1;
    arvalid = 0;
  endtask
  task automatic wait_rvalid();
    int n = 0;
    while (!rvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("rvalid_timeout", rvalid, 1);
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain", {exp_q.size() == 0, busy}, 2'b10);
  endtask
  initial forever begin
    @(posedge clk); cyc++;
    #1;
    app_rd_data_valid = 0;
    if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
      app_rd_data = mq[0].line;
      app_rd_data_valid = 1;
      void'(mq.pop_front());
    end
  end
  initial begin
    logic pv_stall = 0, pa_stall = 0;
    logic [37:0] pv;
    logic [28:0] pa;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_stall = 0; pa_stall = 0;
      end else begin
        if (pv_stall) chk("r_hold", {rvalid, rid, rdata, rlast}, pv);
        if (pa_stall) chk("app_hold", {app_en, app_addr}, pa);
        if (app_en && app_rdy) begin
          mq.push_back('{cyc + 10, line_of(app_addr)});
          if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
          else chk("cmd", {app_cmd, app_addr}, {3'b001, cmd_q.pop_front()});
        end
        if (rvalid && rready) begin
          if (exp_q.size() == 0) chk("beat_unexpected", {rid, rdata, rlast}, 0);
          else chk("beat", {rid, rdata, rlast}, exp_q.pop_front());
        end
        pv_stall = rvalid && !rready; pv = {rvalid, rid, rdata, rlast};
        pa_stall = app_en && !app_rdy; pa = {app_en, app_addr};
      end
    end
  end
  initial begin
    int hi, cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rvalid, rlast, app_en, app_cmd, busy, rid, rdata, app_addr}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("cmd_after_reset", {app_cmd, arready, busy}, 5'b00110);
    do_ar(3, 32'h40);
    wait_drain();
    do_ar(2, 32'h48);
    wait_drain();
    app_rdy = 0;
    do_ar(1, 32'h1230);
    repeat (5) begin
      chk("app_backpressure", {app_en, arready, app_addr}, {2'b10, app_of(32'h1230)});
      @(posedge clk); #1;
    end
    app_rdy = 1;
    @(posedge clk); #1;
    chk("app_released", app_en, 0);
    wait_drain();
    rready = 0;
    for (int i = 0; i < 4; i++) do_ar(4'(i), 32'h400 + 32'h104 * i);
    hi = 0;
    repeat (20) begin hi += int'(arready); @(posedge clk); #1; end
    chk("full_arready", hi, 0);
    chk("full_busy", {busy, rvalid, rid}, 6'b110000);
    rready = 1;
    fork
      do_ar(4, 32'h80C);
      begin
        cnt = 0;
        repeat (16) begin @(negedge clk); cnt += int'(rvalid && rready); end
        chk("no_bubble", cnt, 16);
      end
    join
    @(posedge clk); #1;
    wait_drain();
    rready = 0;
    do_ar(5, 32'h204);
    wait_rvalid();
    rready = 1;
    repeat (3) begin @(posedge clk); #1; end
    rready = 0;
    chk("simul_last", {rvalid, rlast, arready}, 3'b111);
    rready = 1;
    do_ar(6, 32'h30C);
    wait_drain();
    do_ar(7, 32'h58);
    wait_rvalid();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    #1;
    chk("reset_mid_burst", {rvalid, busy, app_en, rlast}, 0);
    exp_q.delete(); cmd_q.delete(); mq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    do_ar(9, 32'h4C);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_end", {rvalid, busy, arready}, 3'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dram_axi_rd_ctrl.md
Name: dram_axi_rd_ctrl

Overview:
- AXI read-channel slave that converts single-address AXI read requests into MIG app-interface read commands.
- Buffers each returned 128-bit app_rd_data line and replays it as a 4-beat 32-bit AXI read burst, critical word first.
- Sits between the AXI bus read port (arvalid/rvalid side) and the MIG app interface (real MIG or the dummy MIG model).
- Supports up to OUTSTD outstanding reads, with in-order return.

Parameters:
- ID_W, 4, width of arid/rid.
- OUTSTD, 4, maximum outstanding reads; depth of both tag and line FIFOs; power of 2, minimum 2.
- APP_AW, 28, width of app_addr.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-high.
- arvalid  in  1  AXI read address valid.
- arready  out  1  AXI read address ready.
- arid  in  ID_W  read transaction id.
- araddr  in  32  byte address; bits [3:2] select the first word returned.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rid  out  ID_W  id of the current burst.
- rdata  out  32  read data beat.
- rlast  out  1  high on beat 4 of each burst.
- app_addr  out  APP_AW  MIG command address.
- app_cmd  out  3  MIG command; always 3'b001 (read).
- app_en  out  1  MIG command enable.
- app_rdy  in  1  MIG command accept.
- app_rd_data  in  128  MIG read line.
- app_rd_data_end  in  1  MIG end of line.
- app_rd_data_valid  in  1  MIG read line valid.
- busy  out  1  high while any read is outstanding or a command is pending.

Behaviour:
- Reset (rst high, asynchronous) drives all outputs to 0 and clears both FIFOs, the outstanding counter and the beat counter. Reset mid-burst discards everything; no stale beat may appear after reset deasserts. app_cmd resets to 0 and is 3'b001 otherwise.
- outst counter, width log2(OUTSTD)+1:
  - increments on AR handshake; decrements on the rlast&&rvalid&&rready handshake.
  - both events in the same cycle: counter unchanged.
- arready = !app_en && (outst < OUTSTD); it is combinational from registered state only.
- AR handshake (arvalid && arready), registered on the next cycle:
  - app_en <= 1.
  - app_addr <= {1'b0, araddr[27:4], 3'b000}.
  - push {arid, araddr[3:2]} into the tag FIFO.
- Command hold: app_en and app_addr are held stable until a cycle with app_en && app_rdy; app_en deasserts on the following cycle. The earliest next AR accept is therefore 1 cycle after the app_rdy acceptance.
- Line capture: app_rd_data_valid pushes app_rd_data into the line FIFO in the same cycle. app_rd_data_end is ignored (always 1 with 4:1 MIG).
  - The line FIFO cannot overflow by construction (credit limit).
  - A sim-only assertion fires if app_rd_data_valid arrives with the line FIFO full, or with the tag FIFO empty (unsolicited data).
- Output state machine:
  - IDLE: if both FIFOs are non-empty, go to BURST with beat=0 and w=tag.start. rvalid rises 1 cycle after the line is written (registered output).
  - BURST: rvalid=1, rid=tag.id, rdata=line[32*idx+31:32*idx] with idx=(w+beat) mod 4, rlast=(beat==3). rvalid, rid, rdata and rlast are held stable while rvalid && !rready.
  - On a handshake with beat<3: beat++.
  - On a handshake with beat==3: pop both FIFOs. If another line and tag are already present, continue back-to-back (no bubble) with beat=0 and the new w; otherwise return to IDLE.
- Ordering: MIG returns lines in command order, so tag and line FIFOs pair up in order; rid order equals arid acceptance order.
- busy = (outst != 0) || app_en.
- Full boundary: with outst==OUTSTD, arready stays low until the last beat of the oldest burst handshakes. arready may reassert in the cycle after that handshake.

Decomposition:
- Shared package: MIG_CMD_READ=3'b001, MIG_CMD_WRITE=3'b000, BEATS_PER_LINE=4, and a line width constant of 128. The write path reuses this package.
- One sub-module is natural: dram_sync_fifo (parameterised width and depth, push/pop/full/empty, asynchronous active-high reset). It is instantiated twice: tag FIFO of width ID_W+2, line FIFO of width 128.

Test Plan:
- Single read: araddr=0x0000_0040, arid=3, app_rdy=1, line=0x44444444_33333333_22222222_11111111 arrives 10 cycles later -> app_addr=0x0000020, app_cmd=001; rdata 11111111, 22222222, 33333333, 44444444; rid=3; rlast only on beat 4.
- Critical word first: araddr=0x48, same line -> beats 33333333, 44444444, 11111111, 22222222.
- App backpressure: app_rdy low for 5 cycles -> app_en and app_addr stable, arready=0 throughout; command accepted on the first app_rdy=1 cycle.
- R backpressure plus outstanding limit: 5 back-to-back ARs with ids 0..4 and rready=0 -> exactly 4 accepted, arready=0 while full. Releasing rready yields ids 0,1,2,3 with no bubble between bursts; id 4 is then accepted and returned.
- Simultaneous events: AR accept in the same cycle as the final rlast handshake -> outst unchanged; no lost or duplicated tag.
- Reset mid-burst: assert rst after beat 2 -> rvalid=0 and busy=0 immediately; a fresh read after reset returns only new data.
